// File: rtl/hp48gx_mmio.sv
// rtl/hp48gx_mmio.sv - HP48GX Saturn nibble-bus MMIO register file (64 nibbles)
// Tracks the controller PC/DP pointers and joins the address space via the CONFIGURE daisy chain.
module hp48gx_mmio (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clk_en,
`ifdef SIM
   input  logic [1:0]  i_phase,
   input  logic [31:0] i_cycle_ctr,
`endif
   input  logic        i_phase_0,
   input  logic        i_debug_cycle,
   input  logic        i_bus_clk_en,
   input  logic        i_bus_is_data,
   input  logic [3:0]  i_bus_nibble_in,
   output logic [3:0]  o_bus_nibble_out,
   input  logic        i_bus_daisy,
   output logic        o_bus_daisy,
   output logic        o_bus_active
);

   typedef enum logic [3:0] {
      M_NOP         = 4'h0,
      M_ID          = 4'h1,
      M_PC_READ     = 4'h2,
      M_DP_READ     = 4'h3,
      M_PC_WRITE    = 4'h4,
      M_DP_WRITE    = 4'h5,
      M_LOAD_PC     = 4'h6,
      M_LOAD_DP     = 4'h7,
      M_CONFIGURE   = 4'h8,
      M_UNCONFIGURE = 4'h9
   } mode_t;

   mode_t       mode, mode_next;
   logic [3:0]  mem [64];
   logic [19:0] base, pc_ptr, dp_ptr, addr_shift, assembled, ptr;
   logic        configured;
   logic [2:0]  addr_cnt, id_cnt;
   logic        strobe, is_pc, is_read, is_write, is_load, hit, last_nibble;
   logic [3:0]  id_nibble;
   logic        unused_inputs;

   assign unused_inputs = ^{i_clk_en
`ifdef SIM
                            , i_phase, i_cycle_ctr
`endif
                           };

   assign strobe      = i_bus_clk_en && i_phase_0 && !i_debug_cycle;
   assign is_pc       = (mode == M_PC_READ) || (mode == M_PC_WRITE);
   assign is_read     = (mode == M_PC_READ) || (mode == M_DP_READ);
   assign is_write    = (mode == M_PC_WRITE) || (mode == M_DP_WRITE);
   assign is_load     = (mode == M_LOAD_PC) || (mode == M_LOAD_DP) ||
                        (mode == M_CONFIGURE) || (mode == M_UNCONFIGURE);
   assign ptr         = is_pc ? pc_ptr : dp_ptr;
   assign hit         = configured && (ptr[19:6] == base[19:6]);
   // Addresses arrive LSB first, so the newest nibble lands in the top of the shifter.
   assign assembled   = {i_bus_nibble_in, addr_shift[19:4]};
   assign last_nibble = is_load && (addr_cnt == 3'd4);

   always_comb begin
      id_nibble = 4'h0;
      case (id_cnt)
         3'd0:    id_nibble = 4'h9;
         3'd1:    id_nibble = 4'h1;
         default: id_nibble = 4'h0;
      endcase
   end

   assign o_bus_daisy      = configured;
   assign o_bus_active     = (is_read && hit) ||
                             ((mode == M_ID) && (id_cnt < 3'd5) && !configured && i_bus_daisy);
   assign o_bus_nibble_out = is_read ? mem[ptr[5:0]] : ((mode == M_ID) ? id_nibble : 4'h0);

   always_comb begin
      mode_next = mode;
      if (strobe) begin
         if (!i_bus_is_data) begin
            mode_next = (i_bus_nibble_in <= 4'h9) ? mode_t'(i_bus_nibble_in) : M_NOP;
         end else if (last_nibble) begin
            case (mode)
               M_LOAD_PC: mode_next = M_PC_READ;
               M_LOAD_DP: mode_next = M_DP_READ;
               default:   mode_next = M_NOP;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mode       <= M_NOP;
         configured <= 1'b0;
         base       <= 20'h0;
         pc_ptr     <= 20'h0;
         dp_ptr     <= 20'h0;
         addr_shift <= 20'h0;
         addr_cnt   <= 3'd0;
         id_cnt     <= 3'd0;
         for (int i = 0; i < 64; i++) mem[i] <= 4'h0;
      end else begin
         mode <= mode_next;
         if (strobe && !i_bus_is_data) begin
            addr_cnt <= 3'd0;
            id_cnt   <= 3'd0;
            if (i_bus_nibble_in == 4'hF) configured <= 1'b0;
         end else if (strobe) begin
            if (is_load) begin
               addr_shift <= assembled;
               addr_cnt   <= last_nibble ? 3'd0 : addr_cnt + 3'd1;
            end
            if (last_nibble) begin
               case (mode)
                  M_LOAD_PC: pc_ptr <= assembled;
                  M_LOAD_DP: dp_ptr <= assembled;
                  M_CONFIGURE:
                     if (!configured && i_bus_daisy) begin
                        base       <= {assembled[19:6], 6'b0};
                        configured <= 1'b1;
                     end
                  M_UNCONFIGURE:
                     if (configured && (assembled[19:6] == base[19:6])) configured <= 1'b0;
                  default: ;
               endcase
            end
            if (is_write && hit) mem[ptr[5:0]] <= i_bus_nibble_in;
            // Pointers follow every transfer so they stay in step with the controller.
            if (is_read || is_write) begin
               if (is_pc) pc_ptr <= pc_ptr + 20'h1;
               else       dp_ptr <= dp_ptr + 20'h1;
            end
            if ((mode == M_ID) && (id_cnt != 3'd5)) id_cnt <= id_cnt + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_hp48gx_mmio.sv
// tb/tb_hp48gx_mmio.sv - self-checking bench for hp48gx_mmio
// Transaction-level model of the nibble bus device compared against the DUT every cycle.
module tb_hp48gx_mmio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_en = 1'b0, ph0 = 1'b0, dbg = 1'b0, is_data = 1'b0, daisy_in = 1'b0;
   logic [3:0]  nib_in = 4'h0;
   logic [3:0]  nib_out;
   logic        daisy_out, active;
`ifdef SIM
   logic [1:0]  phase = 2'd0;
   logic [31:0] cyc = 32'd0;
`endif

   always #5 clk = ~clk;

   hp48gx_mmio dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_clk_en         (bus_en),
`ifdef SIM
      .i_phase          (phase),
      .i_cycle_ctr      (cyc),
`endif
      .i_phase_0        (ph0),
      .i_debug_cycle    (dbg),
      .i_bus_clk_en     (bus_en),
      .i_bus_is_data    (is_data),
      .i_bus_nibble_in  (nib_in),
      .o_bus_nibble_out (nib_out),
      .i_bus_daisy      (daisy_in),
      .o_bus_daisy      (daisy_out),
      .o_bus_active     (active)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: plain integers, an address-nibble queue and a nibble array.
   int         m_mode, m_id, m_pc, m_dp, m_base;
   bit         m_cfg, m_valid = 1'b0;
   logic [3:0] m_mem [64];
   logic [3:0] m_seq [$];

   function automatic bit m_is_read();
      return (m_mode == 2) || (m_mode == 3);
   endfunction

   function automatic int m_ptr();
      return ((m_mode == 2) || (m_mode == 4)) ? m_pc : m_dp;
   endfunction

   function automatic bit m_hit();
      return m_cfg && ((m_ptr() / 64) == (m_base / 64));
   endfunction

   function automatic logic exp_active();
      return (m_is_read() && m_hit()) || (m_mode == 1 && m_id < 5 && !m_cfg && daisy_in);
   endfunction

   function automatic logic [3:0] exp_nibble();
      if (m_is_read()) return m_mem[m_ptr() % 64];
      if (m_mode == 1) return (m_id < 5) ? 4'((32'h00019 >> (4 * m_id)) & 15) : 4'h0;
      return 4'h0;
   endfunction

   task automatic model_step(input logic d, input logic [3:0] n);
      int a;
      if (!d) begin
         m_seq.delete();
         m_id   = 0;
         m_mode = (n <= 9) ? int'(n) : 0;
         if (n == 4'hF) m_cfg = 1'b0;
      end else if (m_mode >= 6 && m_mode <= 9) begin
         m_seq.push_back(n);
         if (m_seq.size() == 5) begin
            a = 0;
            for (int i = 0; i < 5; i++) a += int'(m_seq[i]) << (4 * i);
            m_seq.delete();
            case (m_mode)
               6: begin m_pc = a; m_mode = 2; end
               7: begin m_dp = a; m_mode = 3; end
               8: begin
                  if (!m_cfg && daisy_in) begin m_base = a - (a % 64); m_cfg = 1'b1; end
                  m_mode = 0;
               end
               default: begin
                  if (m_cfg && (a / 64) == (m_base / 64)) m_cfg = 1'b0;
                  m_mode = 0;
               end
            endcase
         end
      end else if (m_mode >= 2 && m_mode <= 5) begin
         if (m_mode >= 4 && m_hit()) m_mem[m_ptr() % 64] = n;
         if (m_mode == 2 || m_mode == 4) m_pc = (m_pc + 1) % (1 << 20);
         else                            m_dp = (m_dp + 1) % (1 << 20);
      end else if (m_mode == 1 && m_id < 5) begin
         m_id++;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_mode = 0; m_id = 0; m_pc = 0; m_dp = 0; m_base = 0; m_cfg = 1'b0;
         m_seq.delete();
         for (int i = 0; i < 64; i++) m_mem[i] = 4'h0;
         m_valid = 1'b1;
      end else if (bus_en && ph0 && !dbg) begin
         model_step(is_data, nib_in);
      end
   endtask

   always @(posedge clk) model_edge();

   always @(negedge clk) begin
      if (m_valid) begin
         check("active", 32'(active), 32'(exp_active()));
         check("nibble_out", 32'(nib_out), 32'(exp_nibble()));
         check("daisy_out", 32'(daisy_out), 32'(m_cfg));
      end
   end

   task automatic xfer(input logic d, input logic [3:0] n, input logic hold = 1'b0);
      is_data = d; nib_in = n; dbg = hold; bus_en = 1'b1; ph0 = 1'b1;
      @(posedge clk); #1;
      bus_en = 1'b0; ph0 = 1'b0; dbg = 1'b0;
   endtask

   task automatic xchk(input logic [3:0] n, input logic ea, input logic [3:0] en, input string name);
      is_data = 1'b1; nib_in = n; bus_en = 1'b1; ph0 = 1'b1;
      @(negedge clk);
      check({name, "_active"}, 32'(active), 32'(ea));
      check({name, "_nibble"}, 32'(nib_out), 32'(en));
      @(posedge clk); #1;
      bus_en = 1'b0; ph0 = 1'b0;
   endtask

   task automatic load5(input logic [3:0] cmd, input logic [19:0] a);
      xfer(1'b0, cmd);
      for (int i = 0; i < 5; i++) xfer(1'b1, a[4*i +: 4]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_daisy", 32'(daisy_out), 32'h0);
      check("reset_active", 32'(active), 32'h0);

      xfer(1'b0, 4'h3);
      xchk(4'h0, 1'b0, 4'h0, "unconf_dp_read");

      daisy_in = 1'b1;
      xfer(1'b0, 4'h1);
      xchk(4'h0, 1'b1, 4'h9, "id0");
      xchk(4'h0, 1'b1, 4'h1, "id1");
      xchk(4'h0, 1'b1, 4'h0, "id2");
      xchk(4'h0, 1'b1, 4'h0, "id3");
      xchk(4'h0, 1'b1, 4'h0, "id4");
      xchk(4'h0, 1'b0, 4'h0, "id5_done");
      daisy_in = 1'b0;
      xfer(1'b0, 4'h1);
      xchk(4'h0, 1'b0, 4'h9, "id_no_daisy");

      daisy_in = 1'b1;
      load5(4'h8, 20'h00100);
      @(negedge clk);
      check("cfg_daisy", 32'(daisy_out), 32'h1);
      check("cfg_base", 32'(dut.base), 32'h00100);
      load5(4'h8, 20'h00200);
      @(negedge clk);
      check("cfg_again_base", 32'(dut.base), 32'h00100);

      load5(4'h7, 20'h00105);
      xfer(1'b0, 4'h5);
      xfer(1'b1, 4'hA);
      xfer(1'b1, 4'hB);
      load5(4'h7, 20'h00105);
      xfer(1'b0, 4'h3);
      xchk(4'h0, 1'b1, 4'hA, "read_a");
      xchk(4'h0, 1'b1, 4'hB, "read_b");
      check("dp_after_reads", 32'(dut.dp_ptr), 32'h00107);
      check("model_dp", 32'(m_dp), 32'h00107);

      load5(4'h6, 20'h00140);
      xchk(4'h0, 1'b0, 4'h0, "pc_out_of_range");
      check("pc_incr", 32'(dut.pc_ptr), 32'h00141);
      load5(4'h6, 20'hFFFFF);
      xfer(1'b1, 4'h0);
      check("pc_wrap", 32'(dut.pc_ptr), 32'h00000);

      xfer(1'b0, 4'h7);
      xfer(1'b1, 4'h1);
      xfer(1'b1, 4'h2);
      xfer(1'b0, 4'h0);
      xfer(1'b1, 4'h3);
      check("abort_keeps_dp", 32'(dut.dp_ptr), 32'h00107);

      xfer(1'b0, 4'h3);
      xfer(1'b1, 4'h0, 1'b1);
      xfer(1'b0, 4'h0, 1'b1);
      xfer(1'b1, 4'h0, 1'b1);
      check("debug_freeze_dp", 32'(dut.dp_ptr), 32'h00107);
      xchk(4'h0, 1'b1, 4'h0, "after_debug_read");

      load5(4'h9, 20'h00100);
      @(negedge clk);
      check("unconf_daisy", 32'(daisy_out), 32'h0);
      load5(4'h7, 20'h00105);
      xchk(4'h0, 1'b0, 4'hA, "unconf_read");

      xfer(1'b0, 4'h7);
      xfer(1'b1, 4'h1);
      xfer(1'b1, 4'h2);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      load5(4'h7, 20'h00003);
      check("reset_mid_load", 32'(dut.dp_ptr), 32'h00003);

      load5(4'h8, 20'h00040);
      xfer(1'b0, 4'hF);
      @(negedge clk);
      check("cmd_f_unconfig", 32'(daisy_out), 32'h0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
